// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive byte buffer placed after the UART receivers. One byte is captured
// on each rising edge of frame_done and is stored in a circular FIFO. A
// bus read strobe (rd_en) returns the oldest byte through data_in.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   frame_done   receiver frame-complete level (may stay high many cycles)
//   rx_byte      received byte, valid while frame_done is high
//   rd_en        one-cycle read strobe of the data register
//   flush        one-cycle strobe, discards all stored bytes
//   err_clr      one-cycle strobe, clears sticky overflow/underflow
//   thresh       interrupt level (0 disables irq)
//   data_in      {24'b0, byte}, valid the cycle after rd_en
//   count        bytes stored (0..DEPTH)
//   empty/full   decoded from count
//   overflow     sticky: byte arrived while full
//   underflow    sticky: read while empty
//   irq          thresh != 0 && count >= thresh
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_done,
    input  logic [7:0]    rx_byte,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          err_clr,
    input  logic [AW:0]   thresh,
    output logic [31:0]   data_in,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic          irq
);

    logic [7:0]    mem [DEPTH];
    logic          done_q_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [31:0]   data_in_reg;
    logic          overflow_reg;
    logic          underflow_reg;

    logic          push_req;
    logic          pop_ok;
    logic          push_ok;
    logic          ovf_event;
    logic          unf_event;

    always_comb begin
        push_req  = frame_done & ~done_q_reg;
        pop_ok    = rd_en & ~empty;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push_ok   = push_req & (~full | pop_ok);
        ovf_event = push_req & full & ~pop_ok & ~flush;
        unf_event = rd_en & empty & ~flush;
        count_next = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Storage has no reset so it maps onto block RAM; only pointers matter.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem[wr_ptr_reg] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // done_q starts high so a frame_done already high at release is ignored.
            done_q_reg    <= 1'b1;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_in_reg   <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            done_q_reg <= frame_done;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                count_reg <= count_next;
                if (rd_en) begin
                    // Read of an empty FIFO returns zero; no read-through of a
                    // byte arriving in the same cycle.
                    data_in_reg <= pop_ok ? {24'b0, mem[rd_ptr_reg]} : 32'b0;
                end
            end
            // A new error event wins over a coincident clear.
            overflow_reg  <= ovf_event | (overflow_reg & ~err_clr);
            underflow_reg <= unf_event | (underflow_reg & ~err_clr);
        end
    end

    assign data_in   = data_in_reg;
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign irq       = (thresh != '0) && (count_reg >= thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_done = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rd_en = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic [AW:0]   thresh = '0;
    logic [31:0]   data_in;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic          irq;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .rx_byte(rx_byte),
        .rd_en(rd_en), .flush(flush), .err_clr(err_clr), .thresh(thresh),
        .data_in(data_in), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of bytes plus the visible register state.
    logic [7:0]  m_q[$];
    bit          m_prev_fd = 1'b1;
    bit          m_ov = 1'b0;
    bit          m_un = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit fd, input logic [7:0] b, input bit rd,
                              input bit fl, input bit ec);
        bit push;
        bit set_ov;
        bit set_un;
        int sz;
        if (rst) begin
            m_q.delete();
            m_ov = 0; m_un = 0; m_data = '0; m_prev_fd = 1;
            return;
        end
        push = fd && !m_prev_fd;
        m_prev_fd = fd;
        set_ov = 0;
        set_un = 0;
        if (fl) begin
            m_q.delete();
        end else begin
            sz = m_q.size();
            if (rd) begin
                if (sz != 0) m_data = {24'b0, m_q.pop_front()};
                else begin m_data = '0; set_un = 1; end
            end
            if (push) begin
                if (sz == DEPTH && !rd) set_ov = 1;
                else m_q.push_back(b);
            end
        end
        if (rd) exp_q.push_back(m_data);
        m_ov = set_ov | (m_ov & !ec);
        m_un = set_un | (m_un & !ec);
    endtask

    task automatic check_status();
        int sz;
        sz = m_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
        chk("irq", 32'(irq), 32'(thresh != 0 && sz >= int'(thresh)));
    endtask

    task automatic step(input bit fd, input logic [7:0] b, input bit rd,
                        input bit fl, input bit ec);
        frame_done = fd; rx_byte = b; rd_en = rd; flush = fl; err_clr = ec;
        @(posedge clk);
        model_edge(fd, b, rd, fl, ec);
        #1;
        check_status();
    endtask

    // Monitor: whenever a read strobe was accepted, data_in must match the
    // next expected value in the scoreboard.
    logic rd_q = 1'b0;
    always @(posedge clk) rd_q <= rd_en && !rst;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got %0h expected none", data_in);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", data_in, e);
                $display("read data_in=%08h expected=%08h", data_in, e);
            end
        end
    end

    initial begin
        // Reset then idle, frame_done held high across release.
        rst = 1;
        step(1, 8'h00, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0);
        rst = 0;
        chk("reset_data_in", data_in, 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        for (int i = 0; i < 3; i++) step(1, 8'h00, 0, 0, 0);
        chk("no_push_at_release", 32'(count), 32'h0);

        // Single push with a long frame_done, then read.
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'hA5, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(1, 8'hA5, 0, 0, 0);
        chk("single_push_count", 32'(count), 32'h1);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("single_read_data", data_in, 32'h0000_00A5);

        // Nine frames into an 8-deep FIFO, then drain.
        for (int i = 1; i <= 9; i++) begin
            step(1, 8'(i), 0, 0, 0);
            step(0, 8'h00, 0, 0, 0);
        end
        chk("overflow_full", 32'(full), 32'h1);
        chk("overflow_flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);

        // Full plus coincident push and read, then wrap-around drain.
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0, 0, 0);
            step(0, 8'h00, 0, 0, 0);
        end
        step(1, 8'h3C, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("full_pushpop_data", data_in, 32'h1);
        chk("full_pushpop_count", 32'(count), 32'h8);
        chk("full_pushpop_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("wrap_last", data_in, 32'h3C);

        // Underflow and err_clr priority.
        step(0, 8'h00, 1, 0, 0);
        chk("underflow_set", 32'(underflow), 32'h1);
        step(0, 8'h00, 1, 0, 1);
        chk("underflow_set_wins", 32'(underflow), 32'h1);
        step(0, 8'h00, 0, 0, 1);
        chk("underflow_cleared", 32'(underflow), 32'h0);

        // Threshold interrupt and flush priority over push.
        thresh = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step(1, 8'(8'h50 + i), 0, 0, 0);
            step(0, 8'h00, 0, 0, 0);
        end
        chk("irq_at_3", 32'(irq), 32'h1);
        step(1, 8'h77, 0, 1, 0);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_irq", 32'(irq), 32'h0);
        step(0, 8'h00, 0, 0, 0);

        // Randomized traffic, alternating fill-heavy and drain-heavy blocks.
        for (int blk = 0; blk < 8; blk++) begin
            thresh = 4'($urandom_range(0, DEPTH));
            for (int i = 0; i < 150; i++) begin
                bit fd;
                bit rd;
                bit fl;
                bit ec;
                rst = ($urandom_range(0, 399) == 0);
                fd = ($urandom_range(0, 1) == 1);
                rd = ($urandom_range(0, 99) < ((blk % 2 == 0) ? 12 : 55));
                fl = ($urandom_range(0, 99) < 2);
                ec = ($urandom_range(0, 99) < 4);
                step(fd, 8'($urandom()), rd, fl, ec);
            end
        end
        rst = 0;
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
